// File: rtl/stdp_pkg.sv
// Shared types and helpers for the STDP learning engine: FSM state encoding,
// saturating add with a parameterised clamp, and a lowest-set-bit finder.
package stdp_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  // Returned by lowest_set when no bit is set; any shift by this yields zero.
  localparam int LSB_NONE = 64;

  function automatic longint sat_add(input longint a, input longint b,
                                     input longint lo, input longint hi);
    longint s;
    s = a + b;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

  function automatic int lowest_set(input logic [63:0] v);
    int r;
    r = LSB_NONE;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/stdp_delta_calc.sv
// Combinational pair-based STDP delta for one synapse: shift-decayed LTP from
// the newest post spike against pre history, LTD from the newest pre spike.
module stdp_delta_calc
  import stdp_pkg::*;
#(
  parameter int WIN     = 16,
  parameter int W_WIDTH = 20,
  parameter int A_PLUS  = 64,
  parameter int A_MINUS = 32
) (
  input  logic [WIN-1:0]            pre_hist,
  input  logic [WIN-1:0]            post_hist,
  output logic signed [W_WIDTH+1:0] delta
);

  int     kp;
  int     kd;
  longint ltp;
  longint ltd;

  always_comb begin
    ltp = 0;
    ltd = 0;
    kp  = lowest_set(64'(pre_hist));
    // LTD only looks at post spikes strictly older than the current timestep
    kd  = lowest_set(64'({post_hist[WIN-1:1], 1'b0}));
    if (post_hist[0] && (|pre_hist)) begin
      ltp = longint'(A_PLUS) >> kp;
    end
    if (pre_hist[0] && (|post_hist[WIN-1:1])) begin
      ltd = longint'(A_MINUS) >> kd;
    end
    delta = (W_WIDTH+2)'(ltp - ltd);
  end

endmodule

// File: rtl/stdp_learning_engine.sv
// STDP learning engine: spike histories, per-tick synapse sweep with saturating
// weight updates. Optional reward-modulated sign via macro STDP_REWARD_EN.
module stdp_learning_engine
  import stdp_pkg::*;
#(
  parameter int NUM_PRE = 16,
  parameter int WIN     = 16,
  parameter int W_WIDTH = 20,
  parameter int A_PLUS  = 64,
  parameter int A_MINUS = 32,
  parameter int W_MAX   = 2**(W_WIDTH-1) - 1,
  parameter int W_MIN   = -(2**(W_WIDTH-1)),
  parameter int INIT_W  = 0,
  parameter int ADDR_W  = $clog2(NUM_PRE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      tick,
  input  logic [NUM_PRE-1:0]        pre_spike,
  input  logic                      post_spike,
  input  logic                      reward_flag,
  input  logic [ADDR_W-1:0]         rd_addr,
  output logic signed [W_WIDTH-1:0] rd_data,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun,
  input  logic                      overrun_clr
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PRE - 1);

  state_t                    state_reg;
  state_t                    state_next;
  logic [ADDR_W-1:0]         idx_reg;
  logic [WIN-1:0]            pre_hist [NUM_PRE];
  logic [WIN-1:0]            post_hist_reg;
  logic signed [W_WIDTH-1:0] weight_reg [NUM_PRE];
  logic                      reward_reg;
  logic                      done_reg;
  logic                      overrun_reg;
  logic                      start;
  logic                      last;
  logic signed [W_WIDTH+1:0] delta;
  longint                    applied;
  logic signed [W_WIDTH-1:0] weight_new;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    last       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick && enable) begin
          start      = 1'b1;
          state_next = SWEEP;
        end
      end
      SWEEP: begin
        if (idx_reg == LAST_IDX) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_pre_hist
      logic [WIN-1:0] hist_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        hist_reg <= '0;
        else if (start) hist_reg <= {hist_reg[WIN-2:0], pre_spike[gi]};
      end
      assign pre_hist[gi] = hist_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_hist_reg <= '0;
      idx_reg       <= '0;
      reward_reg    <= 1'b0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      done_reg <= last;
      if (start) begin
        post_hist_reg <= {post_hist_reg[WIN-2:0], post_spike};
        reward_reg    <= reward_flag;
        idx_reg       <= '0;
      end else if (state_reg == SWEEP) begin
        idx_reg <= last ? '0 : idx_reg + 1'b1;
      end
      // A clear in the same cycle as a dropped tick wins
      if (overrun_clr)
        overrun_reg <= 1'b0;
      else if ((state_reg == SWEEP) && tick && enable)
        overrun_reg <= 1'b1;
    end
  end

  stdp_delta_calc #(
    .WIN     (WIN),
    .W_WIDTH (W_WIDTH),
    .A_PLUS  (A_PLUS),
    .A_MINUS (A_MINUS)
  ) u_delta (
    .pre_hist  (pre_hist[idx_reg]),
    .post_hist (post_hist_reg),
    .delta     (delta)
  );

`ifdef STDP_REWARD_EN
  assign applied = reward_reg ? longint'(delta) : -longint'(delta);
`else
  logic unused_reward;
  assign unused_reward = reward_reg ^ reward_flag;
  assign applied       = longint'(delta);
`endif

  assign weight_new = W_WIDTH'(sat_add(longint'(weight_reg[idx_reg]), applied,
                                       longint'(W_MIN), longint'(W_MAX)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRE; i++) weight_reg[i] <= W_WIDTH'(INIT_W);
    end else if (state_reg == SWEEP) begin
      weight_reg[idx_reg] <= weight_new;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'({1'b0, rd_addr}) < NUM_PRE) rd_data = weight_reg[rd_addr];
  end

  assign busy    = (state_reg == SWEEP);
  assign done    = done_reg;
  assign overrun = overrun_reg;

endmodule

// File: doc/stdp_learning_engine.md
Name: stdp_learning_engine

Overview:
- Parametrised successor to the 16-synapse learning datapath.
- Keeps NUM_PRE pre-synaptic spike-history shift registers, one post-synaptic history register and an internal NUM_PRE-entry weight memory.
- On each timestep strobe, sweeps all synapses one per cycle. Each synapse gets a pair-based STDP update (shift-decayed LTP/LTD) with saturating signed arithmetic.
- Sits between the reservoir neuron array and the readout layer; weights are visible through a combinational read port.

Parameters:
- NUM_PRE, 16: number of pre-synaptic channels/synapses (>=2).
- WIN, 16: spike-history depth in timesteps.
- W_WIDTH, 20: signed weight width.
- A_PLUS, 64: LTP amplitude at offset 0.
- A_MINUS, 32: LTD amplitude at offset 0.
- W_MAX, 2**(W_WIDTH-1)-1: upper weight clamp.
- W_MIN, -2**(W_WIDTH-1): lower weight clamp.
- INIT_W, 0: reset value of every weight.
- ADDR_W, $clog2(NUM_PRE): derived; not to be overridden.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  accept timestep strobes when high
- tick  in  1  timestep strobe; samples spike inputs
- pre_spike  in  NUM_PRE  pre-synaptic spikes for this timestep
- post_spike  in  1  post-synaptic spike for this timestep
- reward_flag  in  1  reward sign; used only with STDP_REWARD_EN
- rd_addr  in  ADDR_W  weight read address
- rd_data  out  W_WIDTH signed  weight[rd_addr], combinational
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at end of sweep
- overrun  out  1  sticky: a tick was dropped
- overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, any time including mid-sweep):
  - histories = 0, weights = INIT_W, state IDLE, idx = 0.
  - busy = 0, done = 0, overrun = 0.
- FSM IDLE -> SWEEP -> IDLE.
  - IDLE, on an edge with tick & enable:
    - each pre history shifts left with pre_spike[i] into bit0; same for post history with post_spike.
    - latch reward_flag; state <= SWEEP; idx <= 0.
  - SWEEP: each edge read-modify-writes weight[idx] and increments idx.
  - At idx == NUM_PRE-1: write, state <= IDLE, done <= 1 for exactly one cycle.
- Latency:
  - tick sampled at edge E0; weight[k] updated at edge E(k+1).
  - busy high from after E0 until after E(NUM_PRE).
  - done high in the cycle after E(NUM_PRE).
- Delta for synapse i (histories: bit0 = newest):
  - LTP: if post[0] = 1 and pre_i has any set bit, kp = index of lowest set bit; ltp = A_PLUS >> kp, else 0.
  - LTD: if pre_i[0] = 1 and post has a set bit at index >= 1, kd = lowest such index; ltd = A_MINUS >> kd, else 0.
  - delta = ltp - ltd, computed at W_WIDTH+2 bits signed.
  - new = clamp(weight + delta, W_MIN, W_MAX). Shifts past the amplitude width yield 0.
- Dropped ticks:
  - tick during SWEEP: ignored, no history shift, overrun <= 1.
  - overrun_clr has priority over a same-cycle set.
- enable low: ticks ignored and do not set overrun; a sweep already running completes.
- rd_addr >= NUM_PRE: rd_data = 0.
- done and a new tick on the same edge: impossible by construction, since the tick is sampled only in IDLE.

Optional Feature:
- Macro: STDP_REWARD_EN.
- Defined: the applied delta is +delta when the latched reward_flag = 1 and -delta when it is 0, then clamped as above.
- Undefined: reward_flag is ignored and delta is applied as computed; the port remains for a stable interface.

Decomposition:
- Package stdp_pkg:
  - state enum (IDLE, SWEEP).
  - saturating-add function, parameterised clamp.
  - lowest-set-bit helper function.
- Sub-module stdp_delta_calc: purely combinational; inputs are one pre history and the post history, output is the signed delta. One instance is muxed by idx.

Test Plan:
All scenarios use NUM_PRE=4, WIN=8, W_WIDTH=12, A_PLUS=64, A_MINUS=32, INIT_W=0, reward macro off unless stated.
1. Reset mid-sweep: tick, then rst at sweep cycle 2 -> all weights 0, busy=0, done=0, overrun=0 immediately.
2. LTP: pre_spike=4'b0100 at tick1, post_spike at tick4 -> after tick4 done, weight[2]=+8, others 0; done pulses 5 cycles after the tick edge.
3. LTD: post_spike at tick1, pre_spike=4'b0010 at tick3 -> weight[1]=-8.
4. Saturation: pre[0] and post spike together on every tick -> weight[0]=64, then +48 per tick; 2032 after tick 42, clamped to 2047 from tick 43 onward.
5. Overrun: second tick asserted during sweep cycle 2 -> ignored, histories unchanged, overrun=1 until overrun_clr; weights equal the single-sweep result.
6. STDP_REWARD_EN defined, scenario 2 with reward_flag=0 at tick4 -> weight[2]=-8; with reward_flag=1 -> weight[2]=+8.
